decode_write_back: RTL and testbench

//   Decode and write-back stage of the sequential Y86-64 processor. Holds the
//   15-entry 64-bit register file. Decodes icode/rA/rB/Cnd into register IDs,

---
 rtl/decode_write_back_if.sv | 27 ++
 rtl/decode_write_back.sv | 112 +++++++++++
 tb/tb_decode_write_back.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_write_back_if.sv
// Decode/write-back bus between fetch/execute and the register file stage.
// Carries instruction fields, write-back data and decoded IDs / read data.
interface decode_write_back_if;
  logic [3:0]  icode;
  logic [3:0]  ifun;
  logic [3:0]  rA;
  logic [3:0]  rB;
  logic        Cnd;
  logic [63:0] valE;
  logic [63:0] valM;
  logic [3:0]  dstE;
  logic [3:0]  dstM;
  logic [3:0]  srcA;
  logic [3:0]  srcB;
  logic [63:0] valA;
  logic [63:0] valB;

  modport master (
    output icode, ifun, rA, rB, Cnd, valE, valM,
    input  dstE, dstM, srcA, srcB, valA, valB
  );

  modport slave (
    input  icode, ifun, rA, rB, Cnd, valE, valM,
    output dstE, dstM, srcA, srcB, valA, valB
  );
endinterface

// File: rtl/decode_write_back.sv
// Y86-64 decode / write-back stage: 15x64 register file, combinational
// decode and reads, clocked write of valE/valM.
module decode_write_back (
  input  logic                 clk,
  input  logic                 reset,
  decode_write_back_if.slave   d,
  output logic [63:0]          rax,
  output logic [63:0]          rcx,
  output logic [63:0]          rdx,
  output logic [63:0]          rbx,
  output logic [63:0]          rsp,
  output logic [63:0]          rbp,
  output logic [63:0]          rsi,
  output logic [63:0]          rdi,
  output logic [63:0]          r8,
  output logic [63:0]          r9,
  output logic [63:0]          r10,
  output logic [63:0]          r11,
  output logic [63:0]          r12,
  output logic [63:0]          r13,
  output logic [63:0]          r14
);
  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RSP   = 4'h4;

  logic [63:0] rf [0:14];
  logic [3:0]  srca, srcb, dste, dstm;
  logic        unused_ifun;

  assign unused_ifun = ^d.ifun;

  always_comb begin
    srca = RNONE;
    srcb = RNONE;
    dste = RNONE;
    dstm = RNONE;
    unique case (d.icode)
      4'h2: begin
        srca = d.rA;
        dste = d.Cnd ? d.rB : RNONE;
      end
      4'h3: dste = d.rB;
      4'h4: begin
        srca = d.rA;
        srcb = d.rB;
      end
      4'h5: begin
        srcb = d.rB;
        dstm = d.rA;
      end
      4'h6: begin
        srca = d.rA;
        srcb = d.rB;
        dste = d.rB;
      end
      4'h8: begin
        srcb = RSP;
        dste = RSP;
      end
      4'h9: begin
        srca = RSP;
        srcb = RSP;
        dste = RSP;
      end
      4'hA: begin
        srca = d.rA;
        srcb = RSP;
        dste = RSP;
      end
      4'hB: begin
        srca = RSP;
        srcb = RSP;
        dste = RSP;
        dstm = d.rA;
      end
      default: ;
    endcase
  end

  assign d.srcA = srca;
  assign d.srcB = srcb;
  assign d.dstE = dste;
  assign d.dstM = dstm;
  assign d.valA = (srca == RNONE) ? 64'd0 : rf[srca];
  assign d.valB = (srcb == RNONE) ? 64'd0 : rf[srcb];

  // dstM is written last so valM wins when both target one register
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 15; i++) rf[i] <= 64'd0;
    end else begin
      if (dste != RNONE) rf[dste] <= d.valE;
      if (dstm != RNONE) rf[dstm] <= d.valM;
    end
  end

  assign rax = rf[0];
  assign rcx = rf[1];
  assign rdx = rf[2];
  assign rbx = rf[3];
  assign rsp = rf[4];
  assign rbp = rf[5];
  assign rsi = rf[6];
  assign rdi = rf[7];
  assign r8  = rf[8];
  assign r9  = rf[9];
  assign r10 = rf[10];
  assign r11 = rf[11];
  assign r12 = rf[12];
  assign r13 = rf[13];
  assign r14 = rf[14];
endmodule

// File: tb/tb_decode_write_back.sv
// Bench for decode_write_back: directed scenarios plus random
// instructions against a register-file reference model.
module tb_decode_write_back;
  localparam logic [3:0] F = 4'hF;

  logic clk;
  logic reset;
  decode_write_back_if di ();
  logic [63:0] obs [0:14];
  logic [63:0] m [0:14];
  int vectors;
  int errors;

  decode_write_back dut (
    .clk(clk), .reset(reset), .d(di),
    .rax(obs[0]), .rcx(obs[1]), .rdx(obs[2]), .rbx(obs[3]),
    .rsp(obs[4]), .rbp(obs[5]), .rsi(obs[6]), .rdi(obs[7]),
    .r8(obs[8]), .r9(obs[9]), .r10(obs[10]), .r11(obs[11]),
    .r12(obs[12]), .r13(obs[13]), .r14(obs[14])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] f_srca(logic [3:0] ic, logic [3:0] ra);
    if (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) return ra;
    if (ic inside {4'h9, 4'hB}) return 4'h4;
    return F;
  endfunction

  function automatic logic [3:0] f_srcb(logic [3:0] ic, logic [3:0] rb);
    if (ic inside {4'h4, 4'h5, 4'h6}) return rb;
    if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
    return F;
  endfunction

  function automatic logic [3:0] f_dste(logic [3:0] ic, logic [3:0] rb,
                                        logic c);
    if (ic == 4'h2) return c ? rb : F;
    if (ic inside {4'h3, 4'h6}) return rb;
    if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
    return F;
  endfunction

  function automatic logic [3:0] f_dstm(logic [3:0] ic, logic [3:0] ra);
    if (ic inside {4'h5, 4'hB}) return ra;
    return F;
  endfunction

  function automatic logic [63:0] f_rd(logic [3:0] id);
    return (id == F) ? 64'd0 : m[id];
  endfunction

  task automatic drive(logic [3:0] ic, logic [3:0] ra, logic [3:0] rb,
                       logic c, logic [63:0] ve, logic [63:0] vm);
    di.icode = ic;
    di.ifun  = 4'($urandom);
    di.rA    = ra;
    di.rB    = rb;
    di.Cnd   = c;
    di.valE  = ve;
    di.valM  = vm;
    #1;
  endtask

  task automatic tick();
    logic [3:0] e, w;
    e = f_dste(di.icode, di.rB, di.Cnd);
    w = f_dstm(di.icode, di.rA);
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 15; i++) m[i] = 64'd0;
    end else begin
      if (e != F) m[e] = di.valE;
      if (w != F) m[w] = di.valM;
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(4'h3, 4'hF, 4'h5, 1'b0, 64'd123, 64'd0);
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 15; i++) begin
      vectors++;
      if (obs[i] !== 64'd0) begin
        errors++;
        $display("FAIL reset_r%0d got %h want 0", i, obs[i]);
      end
    end
  endtask

  task automatic test_directed();
    drive(4'h3, 4'hF, 4'h3, 1'b0, 64'd525, 64'd0);
    vectors++;
    if (di.dstE !== 4'h3) begin
      errors++;
      $display("FAIL irmov_dstE got %h want 3", di.dstE);
    end
    tick();
    vectors++;
    if (obs[3] !== 64'd525) begin
      errors++;
      $display("FAIL irmov_rbx got %0d want 525", obs[3]);
    end
    drive(4'h3, 4'hF, 4'h0, 1'b0, 64'd300, 64'd0);
    tick();
    drive(4'h6, 4'h3, 4'h0, 1'b0, 64'd251, 64'd0);
    vectors++;
    if ({di.srcA, di.srcB, di.dstE} !== {4'h3, 4'h0, 4'h0}
        || di.valA !== 64'd525 || di.valB !== 64'd300) begin
      errors++;
      $display("FAIL opq_dec got %h %h %h %0d %0d want 3 0 0 525 300",
               di.srcA, di.srcB, di.dstE, di.valA, di.valB);
    end
    tick();
    vectors++;
    if (obs[0] !== 64'd251) begin
      errors++;
      $display("FAIL opq_rax got %0d want 251", obs[0]);
    end
    drive(4'h5, 4'h0, 4'h3, 1'b0, 64'd999, 64'd999);
    vectors++;
    if ({di.srcB, di.dstM, di.dstE} !== {4'h3, 4'h0, F}) begin
      errors++;
      $display("FAIL mrmov_dec got %h %h %h want 3 0 f",
               di.srcB, di.dstM, di.dstE);
    end
    tick();
    vectors++;
    if (obs[0] !== 64'd999 || obs[3] !== 64'd525) begin
      errors++;
      $display("FAIL mrmov_wb got %0d %0d want 999 525", obs[0], obs[3]);
    end
    drive(4'h2, 4'h1, 4'h2, 1'b0, 64'd7, 64'd0);
    vectors++;
    if (di.dstE !== F) begin
      errors++;
      $display("FAIL cmov_nt_dstE got %h want f", di.dstE);
    end
    tick();
    vectors++;
    if (obs[2] !== 64'd0) begin
      errors++;
      $display("FAIL cmov_nt_rdx got %0d want 0", obs[2]);
    end
    drive(4'h2, 4'h1, 4'h2, 1'b1, 64'd7, 64'd0);
    tick();
    vectors++;
    if (obs[2] !== 64'd7) begin
      errors++;
      $display("FAIL cmov_t_rdx got %0d want 7", obs[2]);
    end
    drive(4'hB, 4'h4, 4'hF, 1'b0, 64'd8, 64'd77);
    vectors++;
    if ({di.srcA, di.srcB, di.dstE, di.dstM} !== 16'h4444) begin
      errors++;
      $display("FAIL popsp_dec got %h%h%h%h want 4444",
               di.srcA, di.srcB, di.dstE, di.dstM);
    end
    tick();
    vectors++;
    if (obs[4] !== 64'd77) begin
      errors++;
      $display("FAIL popsp_rsp got %0d want 77", obs[4]);
    end
    drive(4'hC, 4'h1, 4'h2, 1'b1, 64'd11, 64'd22);
    vectors++;
    if ({di.srcA, di.srcB, di.dstE, di.dstM} !== 16'hFFFF) begin
      errors++;
      $display("FAIL bad_icode_dec got %h%h%h%h want ffff",
               di.srcA, di.srcB, di.dstE, di.dstM);
    end
    tick();
    for (int i = 0; i < 15; i++) begin
      vectors++;
      if (obs[i] !== m[i]) begin
        errors++;
        $display("FAIL bad_icode_r%0d got %h want %h", i, obs[i], m[i]);
      end
    end
  endtask

  task automatic test_reset_dominates();
    reset = 1'b1;
    drive(4'h3, 4'hF, 4'h1, 1'b0, 64'd5, 64'd0);
    tick();
    reset = 1'b0;
    vectors++;
    if (obs[1] !== 64'd0) begin
      errors++;
      $display("FAIL rst_dom_rcx got %0d want 0", obs[1]);
    end
    vectors++;
    if (di.srcA !== F || di.valA !== 64'd0) begin
      errors++;
      $display("FAIL rst_dom_valA got %h %h want f 0", di.srcA, di.valA);
    end
  endtask

  task automatic test_random();
    logic [3:0] ic, ra, rb;
    for (int n = 0; n < 300; n++) begin
      ic = 4'($urandom);
      ra = 4'($urandom);
      rb = 4'($urandom);
      drive(ic, ra, rb, 1'($urandom),
            {$urandom, $urandom}, {$urandom, $urandom});
      vectors++;
      if (di.srcA !== f_srca(ic, ra) || di.srcB !== f_srcb(ic, rb)
          || di.dstE !== f_dste(ic, rb, di.Cnd)
          || di.dstM !== f_dstm(ic, ra)) begin
        errors++;
        $display("FAIL rnd_dec ic=%h got %h%h%h%h want %h%h%h%h", ic,
                 di.srcA, di.srcB, di.dstE, di.dstM, f_srca(ic, ra),
                 f_srcb(ic, rb), f_dste(ic, rb, di.Cnd), f_dstm(ic, ra));
      end
      vectors++;
      if (di.valA !== f_rd(f_srca(ic, ra))
          || di.valB !== f_rd(f_srcb(ic, rb))) begin
        errors++;
        $display("FAIL rnd_read got %h %h want %h %h", di.valA, di.valB,
                 f_rd(f_srca(ic, ra)), f_rd(f_srcb(ic, rb)));
      end
      tick();
      for (int i = 0; i < 15; i++) begin
        vectors++;
        if (obs[i] !== m[i]) begin
          errors++;
          $display("FAIL rnd_r%0d got %h want %h", i, obs[i], m[i]);
        end
      end
    end
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    for (int i = 0; i < 15; i++) m[i] = 64'd0;
    reset = 1'b1;
    drive(4'h1, 4'hF, 4'hF, 1'b0, 64'd0, 64'd0);
    test_reset();
    test_directed();
    test_reset_dominates();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
